// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: logic/shift/arith ALU, add/sub overflow detect, iterative restoring divider
//
// Ports:
//   clk, rst (async, active-low), flush (aborts divider)
//   aluop_i/alusel_i         operation code and result class
//   reg1_i/reg2_i            operands A and B
//   wd_i/wreg_i              destination register and write enable
//   link_address_i           return address for link-type jumps/branches
//   is_in_delayslot_i, inst_i, excepttype_i, current_inst_address_i
//   wd_o/wreg_o/wdata_o      write-back bundle (wreg_o dropped on overflow and for divides)
//   whilo_o/hi_o/lo_o        HI/LO write (remainder/quotient), valid in divider DONE only
//   stallreq_o               held while a divide is in progress
//   excepttype_o             excepttype_i with the overflow flag merged in
//   is_in_delayslot_o, current_inst_address_o, inst_o  pass-through
module ex_stage #(
  parameter int DATA_W  = 32,
  parameter int OVF_BIT = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       link_address_i,
  input  logic              is_in_delayslot_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       current_inst_address_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o,
  output logic [31:0]       excepttype_o,
  output logic              is_in_delayslot_o,
  output logic [31:0]       current_inst_address_o,
  output logic [31:0]       inst_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  // ---------------- single-cycle datapath ----------------
  logic [DATA_W-1:0] sum, diff, logic_res, shift_res, arith_res, result;
  logic              ovf;
  logic [31:0]       ovf_mask;

  assign sum  = reg1_i + reg2_i;
  assign diff = reg1_i - reg2_i;

  always_comb begin
    ovf = 1'b0;
    if (aluop_i == EXE_ADD_OP)
      ovf = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
    else if (aluop_i == EXE_SUB_OP)
      ovf = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (diff[DATA_W-1] != reg1_i[DATA_W-1]);
    ovf_mask          = '0;
    ovf_mask[OVF_BIT] = ovf;
  end

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[SH_W-1:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[SH_W-1:0];
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[SH_W-1:0];
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: arith_res = sum;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
      EXE_SLTU_OP: arith_res = DATA_W'(reg1_i < reg2_i);
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC:       result = logic_res;
      EXE_RES_SHIFT:       result = shift_res;
      EXE_RES_ARITHMETIC:  result = arith_res;
      EXE_RES_JUMP_BRANCH: result = link_address_i;
      default:             result = '0;
    endcase
  end

  // ---------------- restoring divider ----------------
  div_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] div_q, div_r, div_d;
  logic              quot_neg, rem_neg;
  logic              is_div, is_signed;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   trial;

  assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_signed = (aluop_i == EXE_DIV_OP);
  assign a_mag     = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
  assign b_mag     = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
  // Partial remainder shifted left with the next dividend bit, minus divisor;
  // the extra top bit is the borrow that decides whether to restore.
  assign trial     = {div_r, div_q[DATA_W-1]} - {1'b0, div_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_IDLE;
      count    <= '0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (is_div) begin
            div_d    <= b_mag;
            div_r    <= '0;
            count    <= '0;
            quot_neg <= is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            rem_neg  <= is_signed && reg1_i[DATA_W-1];
            if (reg2_i == '0) begin
              div_q <= '0;
              state <= DIV_DONE;
            end else begin
              div_q <= a_mag;
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!trial[DATA_W]) begin
            div_r <= trial[DATA_W-1:0];
            div_q <= {div_q[DATA_W-2:0], 1'b1};
          end else begin
            div_r <= {div_r[DATA_W-2:0], div_q[DATA_W-1]};
            div_q <= {div_q[DATA_W-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(DATA_W - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  // ---------------- output bundle ----------------
  // Everything is forced to zero while reset is held, including pass-throughs.
  always_comb begin
    wd_o                   = '0;
    wreg_o                 = 1'b0;
    wdata_o                = '0;
    whilo_o                = 1'b0;
    hi_o                   = '0;
    lo_o                   = '0;
    stallreq_o             = 1'b0;
    excepttype_o           = '0;
    is_in_delayslot_o      = 1'b0;
    current_inst_address_o = '0;
    inst_o                 = '0;
    if (rst) begin
      wd_o                   = wd_i;
      wreg_o                 = wreg_i && !ovf && !is_div;
      wdata_o                = result;
      excepttype_o           = excepttype_i | ovf_mask;
      is_in_delayslot_o      = is_in_delayslot_i;
      current_inst_address_o = current_inst_address_i;
      inst_o                 = inst_i;
      stallreq_o             = !flush && ((state == DIV_IDLE && is_div) || state == DIV_BUSY);
      if (state == DIV_DONE && !flush) begin
        whilo_o = 1'b1;
        lo_o    = quot_neg ? -div_q : div_q;
        hi_o    = rem_neg  ? -div_r : div_r;
      end
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Consumes the registered ID/EX bundle and produces the write-back bundle for the EX/MEM register.
- Integer ALU, shift and compare ops are single-cycle combinational.
- DIV/DIVU run on an internal 32-iteration restoring divider FSM. The FSM raises a stall request to the pipeline controller until the result is ready.
- Detects signed add/sub overflow and merges it into the exception word passed downstream.

Parameters:
- DATA_W, 32, datapath width. Fixed at 32; the divider iteration count equals DATA_W.
- OVF_BIT, 12, bit of excepttype_o set on arithmetic overflow.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  exception flush from ctrl; aborts divider.
- aluop_i  in  8  operation code (codebase EXE_*_OP defines).
- alusel_i  in  3  result class (codebase EXE_RES_* defines).
- reg1_i  in  32  operand A (rs).
- reg2_i  in  32  operand B (rt or immediate).
- wd_i  in  5  destination register.
- wreg_i  in  1  destination write enable.
- link_address_i  in  32  return address for link-type jumps/branches.
- is_in_delayslot_i  in  1  current instruction is in a delay slot.
- inst_i  in  32  raw instruction word.
- excepttype_i  in  32  exception flags from ID.
- current_inst_address_i  in  32  PC of current instruction.
- wd_o  out  5  destination register.
- wreg_o  out  1  write enable; forced 0 on overflow.
- wdata_o  out  32  result.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  32  HI value (remainder).
- lo_o  out  32  LO value (quotient).
- stallreq_o  out  1  stall request to ctrl.
- excepttype_o  out  32  excepttype_i OR overflow flag.
- is_in_delayslot_o  out  1  pass-through.
- current_inst_address_o  out  32  pass-through.
- inst_o  out  32  pass-through.

Behaviour:
- While rst is low:
  - all outputs are 0;
  - divider FSM is in IDLE;
  - divider registers are 0.
- Deassertion takes effect at the next clk edge.
- Logic class (alusel LOGIC):
  - AND, OR, XOR, NOR of reg1_i and reg2_i.
- Shift class (alusel SHIFT):
  - SLL, SRL, SRA of reg2_i by reg1_i[4:0].
- Arithmetic class (alusel ARITH):
  - ADD/ADDU/SUB/SUBU are 32-bit wrap.
  - SLT is a signed compare, SLTU unsigned; result is 1 or 0.
- Jump/branch class (alusel JUMP_BRANCH): wdata_o = link_address_i.
- NOP or unknown op: wdata_o = 0, wreg_o = wreg_i.
- Overflow:
  - Overflow is defined for ADD/SUB only: operands of the same sign for ADD (opposite sign for SUB) and a result sign that differs.
  - On overflow: wreg_o = 0 and excepttype_o[OVF_BIT] = 1.
  - ADDU/SUBU never flag.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Entered when aluop_i is DIV/DIVU and flush = 0.
  - Latch |operands| (signed) or raw operands (unsigned), plus sign info.
  - counter = 0. stallreq_o = 1 combinationally in this cycle.
  - If divisor = 0, go to DONE with quotient = 0, remainder = 0.
  - Otherwise go to BUSY.
- BUSY:
  - One restoring shift/subtract step per cycle; counter += 1; stallreq_o = 1.
  - After step 31 (counter = 31) go to DONE.
- DONE:
  - stallreq_o = 0, whilo_o = 1.
  - DIV: quotient is negated if operand signs differ; remainder takes the sign of the dividend.
  - lo_o = quotient, hi_o = remainder. wreg_o = 0 for DIV/DIVU.
  - Next state is IDLE.
- Divider timing:
  - Non-zero divisor: stallreq_o is high for 33 consecutive cycles; the result appears in the 34th cycle.
  - Zero divisor: stallreq_o is high for 1 cycle.
- ctrl holds ID/EX stable while stallreq_o = 1, so the same DIV remains presented.
- After DONE→IDLE, the FSM does not restart on the same instruction: the held DIV is consumed because the pipeline advances on the DONE cycle.
- Flush:
  - Flush in any state forces IDLE at the next edge. stallreq_o = 0 and whilo_o = 0 in the flush cycle.
  - Flush in IDLE suppresses the divide start.
- whilo_o = 0 for all non-divide ops; hi_o and lo_o are 0 when whilo_o = 0.
- Pass-through fields are combinational from inputs; zero latency.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, wreg_i = 1 → wdata_o = 0x80000000, wreg_o = 0, excepttype_o[12] = 1. ADDU with same operands → wreg_o = 1, excepttype_o = excepttype_i.
- SRA reg2 = 0x80000000, reg1 = 4 → 0xF8000000. SLT −1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0.
- DIV −7 / 2 held stable → stallreq_o high 33 cycles, then lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, whilo_o = 1 for one cycle.
- DIVU 100 / 0 → stallreq_o high 1 cycle, next cycle hi_o = lo_o = 0, whilo_o = 1.
- DIVU 0xFFFFFFFF / 3 with flush pulsed at BUSY counter = 10 → next cycle stallreq_o = 0, whilo_o = 0. Restart from IDLE yields lo_o = 0x55555555, hi_o = 0.
- rst driven low mid-BUSY (asynchronous, between edges) → all outputs 0 immediately. After release, DIV 9 / 3 completes normally: lo_o = 3, hi_o = 0.
